// File: rtl/sub64_reg.sv
// sub64_reg: registered 64-bit two's-complement subtractor for the Y86-64
// execute path. A - B is formed as A + ~B + 1 on a ripple-carry chain of
// full adders; result and condition flags are captured with 1-cycle latency.

module sub64_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module sub64_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero,
  output logic             Sign
);

  logic [WIDTH-1:0] b_inv;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] diff;
  logic             diff_cout;
  logic             diff_ovf;
  logic             diff_zero;
  logic             diff_sign;

  // Subtraction as addition: invert the subtrahend and inject a carry-in of 1.
  assign b_inv    = ~B;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    sub64_full_adder u_fa (
      .a    (A[i]),
      .b    (b_inv[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  // Carry out of the top stage means no borrow (A >= B unsigned); signed
  // overflow is a mismatch between carry into and out of the sign bit.
  assign diff_cout = carry[WIDTH];
  assign diff_ovf  = carry[WIDTH-1] ^ carry[WIDTH];
  assign diff_zero = (diff == '0);
  assign diff_sign = diff[WIDTH-1];

  // Output register: reset clears everything, idle cycles hold result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Cout      <= 1'b0;
      Overflow  <= 1'b0;
      Zero      <= 1'b0;
      Sign      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Result   <= diff;
        Cout     <= diff_cout;
        Overflow <= diff_ovf;
        Zero     <= diff_zero;
        Sign     <= diff_sign;
      end
    end
  end

endmodule

// File: tb/tb_sub64_reg.sv
// tb_sub64_reg: directed and random checks of sub64_reg against an
// arithmetic reference model of A - B and its condition flags.

module tb_sub64_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] A;
  logic [63:0] B;
  logic        out_valid;
  logic [63:0] Result;
  logic        Cout;
  logic        Overflow;
  logic        Zero;
  logic        Sign;

  int checks;
  int failures;

  logic        m_valid;
  logic [63:0] m_result;
  logic        m_cout;
  logic        m_ovf;
  logic        m_zero;
  logic        m_sign;

  sub64_reg #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .Result    (Result),
    .Cout      (Cout),
    .Overflow  (Overflow),
    .Zero      (Zero),
    .Sign      (Sign)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned and signed arithmetic on widened operands.
  task automatic model_op(input logic [63:0] a, input logic [63:0] b);
    logic signed [64:0] sfull;
    sfull    = $signed({a[63], a}) - $signed({b[63], b});
    m_result = a - b;
    m_cout   = (a >= b);
    m_ovf    = (sfull > 65'sd9223372036854775807) || (sfull < -65'sd9223372036854775808);
    m_zero   = (m_result == 64'd0);
    m_sign   = m_result[63];
  endtask

  // One clock cycle: drive on negedge, update model at posedge, compare after.
  task automatic step(input logic r, input logic v, input logic [63:0] a, input logic [63:0] b,
                      input string tag);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    A        = a;
    B        = b;
    @(posedge clk);
    if (r) begin
      m_valid  = 1'b0;
      m_result = '0;
      m_cout   = 1'b0;
      m_ovf    = 1'b0;
      m_zero   = 1'b0;
      m_sign   = 1'b0;
    end else begin
      m_valid = v;
      if (v) model_op(a, b);
    end
    #1;
    check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, m_valid});
    check({tag, ".Result"},    Result,             m_result);
    check({tag, ".Cout"},      {63'd0, Cout},      {63'd0, m_cout});
    check({tag, ".Overflow"},  {63'd0, Overflow},  {63'd0, m_ovf});
    check({tag, ".Zero"},      {63'd0, Zero},      {63'd0, m_zero});
    check({tag, ".Sign"},      {63'd0, Sign},      {63'd0, m_sign});
  endtask

  function automatic logic [63:0] rand64();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = 64'd1;
      2: v = 64'h7FFF_FFFF_FFFF_FFFF;
      3: v = 64'h8000_0000_0000_0000;
      4: v = 64'hFFFF_FFFF_FFFF_FFFF;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rr;
    logic        rv;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;

    // Reset held two cycles while valid operands are offered.
    step(1'b1, 1'b1, 64'h1111_2222_3333_4444, 64'h0000_0000_0000_0001, "reset0");
    step(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF, "reset1");

    // Basic positive results.
    step(1'b0, 1'b1, 64'hB, 64'h4, "b_minus_4");
    check("b_minus_4.exact", Result, 64'h7);
    step(1'b0, 1'b1, 64'h13, 64'h6, "13_minus_6");
    check("13_minus_6.exact", Result, 64'hD);

    // Borrow cases.
    step(1'b0, 1'b1, 64'hB, 64'hC, "borrow1");
    check("borrow1.exact", Result, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b0, 1'b1, 64'h5, 64'h1B, "borrow2");
    check("borrow2.exact", Result, 64'hFFFF_FFFF_FFFF_FFEA);
    step(1'b0, 1'b1, 64'h0, 64'h1, "zero_minus_one");

    // Signed overflow, both directions.
    step(1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "ovf_pos");
    check("ovf_pos.flag", {63'd0, Overflow}, 64'd1);
    step(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'h1, "ovf_neg");
    check("ovf_neg.exact", Result, 64'h7FFF_FFFF_FFFF_FFFF);

    // Equality and B = 0.
    step(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, "equal");
    check("equal.zero", {63'd0, Zero}, 64'd1);
    step(1'b0, 1'b1, 64'hCAFE_F00D_1234_5678, 64'h0, "b_zero");

    // Idle cycles hold result/flags; reset between ops drops the op under reset.
    step(1'b0, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'h1, "idle1");
    step(1'b0, 1'b0, 64'h0, 64'h0, "idle2");
    step(1'b0, 1'b1, 64'h100, 64'h1, "pre_rst");
    step(1'b1, 1'b1, 64'h55, 64'h22, "mid_rst");
    step(1'b0, 1'b1, 64'h42, 64'h40, "post_rst");

    // Randomized back-to-back traffic with idles and occasional resets.
    for (int i = 0; i < 300; i++) begin
      ra = rand64();
      rb = ($urandom_range(0, 9) == 0) ? ra : rand64();
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 24) == 0);
      step(rr, rv, ra, rb, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
